vga_frame_reader: RTL and testbench

Scan-out engine for the 640x480 framebuffer that the sprite/background merge stage writes. It generates 640x480@60 Hz VGA timing and issues sequential read addresses to the framebuffer's synchronous read port. Returned RGB332 pixels are expanded to 4-bit-per-channel VGA outputs, with sync and blanking aligned to the pixel data. It is the consumer end of the framebuffer interface, and its `frame_start` pulse paces the merge stage.

---
 rtl/vga_frame_reader.sv | 165 ++++++++++++++++
 tb/tb_vga_frame_reader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// VGA scan-out engine: raster timing, sequential framebuffer reads and RGB332 expansion.
// Stage 0 issues reads; a delay line sized to the read latency keeps sync/blank aligned with returned pixels.
module vga_frame_reader #(
    parameter int          READ_LATENCY    = 1,
    parameter logic [7:0]  TRANSPARENT_KEY = 8'hEF,
    parameter logic [7:0]  KEY_FILL        = 8'h00,
    parameter int          H_VISIBLE       = 640,
    parameter int          H_FRONT         = 16,
    parameter int          H_SYNC          = 96,
    parameter int          H_BACK          = 48,
    parameter int          V_VISIBLE       = 480,
    parameter int          V_FRONT         = 10,
    parameter int          V_SYNC          = 2,
    parameter int          V_BACK          = 33
) (
    input  logic        clk,
    input  logic        reset,
    output logic [18:0] fb_addr,
    output logic        fb_rd_en,
    input  logic [7:0]  fb_rdata,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic        frame_start
);

    localparam logic [9:0]  H_LAST       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]  V_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0]  H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0]  H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [18:0] ADDR_LAST    = 19'(H_VISIBLE * V_VISIBLE - 1);

    logic [9:0] h_r;
    logic [9:0] v_r;
    logic [9:0] h_nxt_s;
    logic [9:0] v_nxt_s;
    logic       run_r;
    logic       hs0_r;
    logic       vs0_r;
    logic       vis_nxt_s;
    logic       hs_nxt_s;
    logic       vs_nxt_s;
    logic [READ_LATENCY-1:0] vis_d_r;
    logic [READ_LATENCY-1:0] hs_d_r;
    logic [READ_LATENCY-1:0] vs_d_r;

    function automatic logic [11:0] expand_rgb332(input logic [7:0] px);
        logic [7:0] p;
        p = (px == TRANSPARENT_KEY) ? KEY_FILL : px;
        return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
    endfunction

    // Next raster position and the timing flags that go with it
    always_comb begin
        h_nxt_s = h_r;
        v_nxt_s = v_r;
        if (h_r == H_LAST) begin
            h_nxt_s = 10'd0;
            if (v_r == V_LAST) begin
                v_nxt_s = 10'd0;
            end else begin
                v_nxt_s = v_r + 10'd1;
            end
        end else begin
            h_nxt_s = h_r + 10'd1;
            v_nxt_s = v_r;
        end
        vis_nxt_s = (h_nxt_s < H_VIS) && (v_nxt_s < V_VIS);
        hs_nxt_s  = !((h_nxt_s >= H_SYNC_START) && (h_nxt_s < H_SYNC_END));
        vs_nxt_s  = !((v_nxt_s >= V_SYNC_START) && (v_nxt_s < V_SYNC_END));
    end

    // Stage 0: the first clock after reset presents (0,0); afterwards the raster advances every clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_r       <= 1'b0;
            h_r         <= 10'd0;
            v_r         <= 10'd0;
            fb_rd_en    <= 1'b0;
            fb_addr     <= 19'd0;
            frame_start <= 1'b0;
            hs0_r       <= 1'b1;
            vs0_r       <= 1'b1;
        end else if (!run_r) begin
            run_r       <= 1'b1;
            h_r         <= 10'd0;
            v_r         <= 10'd0;
            fb_rd_en    <= 1'b1;
            fb_addr     <= 19'd0;
            frame_start <= 1'b1;
            hs0_r       <= 1'b1;
            vs0_r       <= 1'b1;
        end else begin
            h_r         <= h_nxt_s;
            v_r         <= v_nxt_s;
            fb_rd_en    <= vis_nxt_s;
            frame_start <= (h_nxt_s == 10'd0) && (v_nxt_s == 10'd0);
            hs0_r       <= hs_nxt_s;
            vs0_r       <= vs_nxt_s;
            if (fb_rd_en) begin
                fb_addr <= (fb_addr == ADDR_LAST) ? 19'd0 : fb_addr + 19'd1;
            end else begin
                fb_addr <= fb_addr;
            end
        end
    end

    generate
        if (READ_LATENCY > 1) begin : g_delay_multi
            // Delay line matching the framebuffer read latency
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vis_d_r <= {READ_LATENCY{1'b0}};
                    hs_d_r  <= {READ_LATENCY{1'b1}};
                    vs_d_r  <= {READ_LATENCY{1'b1}};
                end else begin
                    vis_d_r <= {vis_d_r[READ_LATENCY-2:0], fb_rd_en};
                    hs_d_r  <= {hs_d_r[READ_LATENCY-2:0], hs0_r};
                    vs_d_r  <= {vs_d_r[READ_LATENCY-2:0], vs0_r};
                end
            end
        end else begin : g_delay_single
            // Single-stage delay for a one-cycle read port
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vis_d_r <= 1'b0;
                    hs_d_r  <= 1'b1;
                    vs_d_r  <= 1'b1;
                end else begin
                    vis_d_r <= fb_rd_en;
                    hs_d_r  <= hs0_r;
                    vs_d_r  <= vs0_r;
                end
            end
        end
    endgenerate

    // Output register: blanked pixels ignore fb_rdata entirely
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {vga_r, vga_g, vga_b} <= 12'h000;
            vga_de    <= 1'b0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            vga_hsync <= hs_d_r[READ_LATENCY-1];
            vga_vsync <= vs_d_r[READ_LATENCY-1];
            if (vis_d_r[READ_LATENCY-1]) begin
                {vga_r, vga_g, vga_b} <= expand_rgb332(fb_rdata);
                vga_de <= 1'b1;
            end else begin
                {vga_r, vga_g, vga_b} <= 12'h000;
                vga_de <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: one full-size instance plus reduced-geometry instances at latencies 1..4,
// all compared cycle by cycle against a raster model computed from the cycle index.
module tb_vga_frame_reader;

    localparam int NDUT = 5;
    localparam int LAT_A [NDUT] = '{1, 1, 2, 3, 4};
    localparam int HV_A  [NDUT] = '{640, 40, 40, 40, 40};
    localparam int HFP_A [NDUT] = '{16, 4, 4, 4, 4};
    localparam int HSY_A [NDUT] = '{96, 6, 6, 6, 6};
    localparam int HBP_A [NDUT] = '{48, 6, 6, 6, 6};
    localparam int VV_A  [NDUT] = '{480, 10, 10, 10, 10};
    localparam int VFP_A [NDUT] = '{10, 2, 2, 2, 2};
    localparam int VSY_A [NDUT] = '{2, 2, 2, 2, 2};
    localparam int VBP_A [NDUT] = '{33, 3, 3, 3, 3};
    localparam logic [35:0] RESET_OBS = {12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0};

    logic        clk;
    logic        reset;
    logic [7:0]  tbl [256];
    logic [35:0] obs [NDUT];
    int          nvec;
    int          nerr;
    int          cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : gen_dut
            logic [7:0]  rq [LAT_A[gi]];
            logic [3:0]  red_s, grn_s, blu_s;
            logic        hs_s, vs_s, de_s, fs_s, rd_s;
            logic [18:0] addr_s;

            vga_frame_reader #(
                .READ_LATENCY(LAT_A[gi]), .TRANSPARENT_KEY(8'hEF), .KEY_FILL(8'h1C),
                .H_VISIBLE(HV_A[gi]), .H_FRONT(HFP_A[gi]), .H_SYNC(HSY_A[gi]), .H_BACK(HBP_A[gi]),
                .V_VISIBLE(VV_A[gi]), .V_FRONT(VFP_A[gi]), .V_SYNC(VSY_A[gi]), .V_BACK(VBP_A[gi])
            ) u_dut (
                .clk(clk), .reset(reset), .fb_addr(addr_s), .fb_rd_en(rd_s),
                .fb_rdata(rq[LAT_A[gi]-1]), .vga_r(red_s), .vga_g(grn_s), .vga_b(blu_s),
                .vga_hsync(hs_s), .vga_vsync(vs_s), .vga_de(de_s), .frame_start(fs_s)
            );

            // Fixed-latency framebuffer: returns data every cycle whether or not a read was strobed
            always @(posedge clk) begin
                rq[0] <= tbl[addr_s[7:0]];
                for (int i = 1; i < LAT_A[gi]; i++) rq[i] <= rq[i-1];
            end

            assign obs[gi] = {red_s, grn_s, blu_s, de_s, hs_s, vs_s, fs_s, rd_s, addr_s};
        end
    endgenerate

    function automatic int h_total(int k);
        return HV_A[k] + HFP_A[k] + HSY_A[k] + HBP_A[k];
    endfunction

    function automatic int v_total(int k);
        return VV_A[k] + VFP_A[k] + VSY_A[k] + VBP_A[k];
    endfunction

    // Expected observation n clocks after the first post-reset edge, from raster arithmetic
    function automatic logic [35:0] model(int k, int n);
        int ht, vt, h, v, m, hm, vm;
        logic [7:0]  p;
        logic [11:0] rgb;
        logic        de, hs, vs, fs, rd;
        logic [18:0] addr;
        ht = h_total(k);
        vt = v_total(k);
        rgb = 12'h000; de = 1'b0; hs = 1'b1; vs = 1'b1; fs = 1'b0; rd = 1'b0; addr = 19'd0;
        if (n >= 0) begin
            h  = n % ht;
            v  = (n / ht) % vt;
            rd = (h < HV_A[k]) && (v < VV_A[k]);
            fs = (h == 0) && (v == 0);
            if (rd) addr = 19'(v * HV_A[k] + h);
            else if (v < VV_A[k]) addr = 19'(((v + 1) * HV_A[k]) % (HV_A[k] * VV_A[k]));
            else addr = 19'd0;
        end
        m = n - LAT_A[k] - 1;
        if (m >= 0) begin
            hm = m % ht;
            vm = (m / ht) % vt;
            hs = !(hm >= HV_A[k] + HFP_A[k] && hm < HV_A[k] + HFP_A[k] + HSY_A[k]);
            vs = !(vm >= VV_A[k] + VFP_A[k] && vm < VV_A[k] + VFP_A[k] + VSY_A[k]);
            if (hm < HV_A[k] && vm < VV_A[k]) begin
                de = 1'b1;
                p = tbl[(vm * HV_A[k] + hm) % 256];
                if (p == 8'hEF) p = 8'h1C;
                rgb = {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
            end
        end
        return {rgb, de, hs, vs, fs, rd, addr};
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = -1;
    endtask

    task automatic test_reset();
        logic [35:0] exp;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            nvec++;
            if (obs[k] !== RESET_OBS) begin
                nerr++;
                $display("FAIL reset_values dut%0d: got %h expected %h", k, obs[k], RESET_OBS);
            end
        end
        reset = 1'b0;
        cyc = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); cyc++;
            for (int k = 0; k < NDUT; k++) begin
                exp = model(k, cyc);
                nvec++;
                if (obs[k] !== exp) begin
                    nerr++;
                    $display("FAIL reset_release dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp);
                end
            end
        end
    endtask

    task automatic test_first_pixel();
        int rise [NDUT];
        logic [35:0] exp;
        for (int k = 0; k < NDUT; k++) rise[k] = -1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); cyc++;
            for (int k = 0; k < NDUT; k++) begin
                if (rise[k] < 0 && obs[k][23]) begin
                    rise[k] = cyc;
                    exp = model(k, LAT_A[k] + 1);
                    nvec++;
                    if (obs[k][35:24] !== exp[35:24]) begin
                        nerr++;
                        $display("FAIL first_pixel_rgb dut%0d: got %h expected %h", k, obs[k][35:24], exp[35:24]);
                    end
                end
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            nvec++;
            if (rise[k] !== LAT_A[k] + 1) begin
                nerr++;
                $display("FAIL de_rise_cycle dut%0d: got %0d expected %0d", k, rise[k], LAT_A[k] + 1);
            end
        end
    endtask

    task automatic test_scan();
        int hs_lo [NDUT], vs_lo [NDUT], de_hi [NDUT], fs_cnt [NDUT], hs_fall [NDUT];
        int win, lat, last_cyc, next_cyc, hold_bad;
        logic [18:0] next_addr;
        logic [35:0] exp;
        for (int k = 0; k < NDUT; k++) begin
            hs_lo[k] = 0; vs_lo[k] = 0; de_hi[k] = 0; fs_cnt[k] = 0; hs_fall[k] = -1;
        end
        last_cyc = -1; next_cyc = -1; hold_bad = 0; next_addr = 19'h7FFFF;
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk); cyc++;
            for (int k = 0; k < NDUT; k++) begin
                exp = model(k, cyc);
                nvec++;
                if (obs[k] !== exp) begin
                    nerr++;
                    $display("FAIL scan dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp);
                end
                lat = LAT_A[k];
                win = (k == 0) ? h_total(k) : h_total(k) * v_total(k);
                if (cyc >= lat + 1 && cyc < lat + 1 + win) begin
                    if (!obs[k][22]) hs_lo[k]++;
                    if (!obs[k][21]) vs_lo[k]++;
                    if (obs[k][23]) de_hi[k]++;
                    if (hs_fall[k] < 0 && !obs[k][22]) hs_fall[k] = cyc;
                end
                if (cyc < win && obs[k][20]) fs_cnt[k]++;
            end
            if (last_cyc < 0) begin
                if (obs[1][19] && obs[1][18:0] == 19'(HV_A[1] * VV_A[1] - 1)) last_cyc = cyc;
            end else if (next_cyc < 0) begin
                if (obs[1][19]) begin
                    next_cyc = cyc;
                    next_addr = obs[1][18:0];
                end else if (obs[1][18:0] != 19'd0) begin
                    hold_bad++;
                end
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            nvec += 5;
            if (hs_lo[k] != ((k == 0) ? HSY_A[k] : HSY_A[k] * v_total(k))) begin
                nerr++; $display("FAIL hsync_low_count dut%0d: got %0d", k, hs_lo[k]);
            end
            if (vs_lo[k] != ((k == 0) ? 0 : VSY_A[k] * h_total(k))) begin
                nerr++; $display("FAIL vsync_low_count dut%0d: got %0d", k, vs_lo[k]);
            end
            if (de_hi[k] != ((k == 0) ? HV_A[k] : HV_A[k] * VV_A[k])) begin
                nerr++; $display("FAIL de_high_count dut%0d: got %0d", k, de_hi[k]);
            end
            if (fs_cnt[k] != 1) begin
                nerr++; $display("FAIL frame_start_count dut%0d: got %0d expected 1", k, fs_cnt[k]);
            end
            if (hs_fall[k] != HV_A[k] + HFP_A[k] + LAT_A[k] + 1) begin
                nerr++;
                $display("FAIL hsync_start dut%0d: got %0d expected %0d", k, hs_fall[k], HV_A[k] + HFP_A[k] + LAT_A[k] + 1);
            end
        end
        nvec += 3;
        if (last_cyc != (VV_A[1] - 1) * h_total(1) + HV_A[1] - 1) begin
            nerr++; $display("FAIL last_read_cycle: got %0d", last_cyc);
        end
        if (next_cyc != h_total(1) * v_total(1) || next_addr !== 19'd0) begin
            nerr++; $display("FAIL wrap_read: got cyc %0d addr %0d expected cyc %0d addr 0", next_cyc, next_addr, h_total(1) * v_total(1));
        end
        if (hold_bad != 0) begin
            nerr++; $display("FAIL addr_hold_vblank: got %0d nonzero cycles expected 0", hold_bad);
        end
    endtask

    task automatic test_key_colors();
        logic [11:0] want [4];
        want[0] = 12'hFFF;
        want[1] = 12'h99A;
        want[2] = 12'h0F0;
        want[3] = 12'hF6A;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); cyc++;
            if (cyc >= LAT_A[0] + 2 && cyc <= LAT_A[0] + 5) begin
                nvec++;
                if (obs[0][35:24] !== want[cyc - LAT_A[0] - 2]) begin
                    nerr++;
                    $display("FAIL key_color px%0d: got %h expected %h", cyc - LAT_A[0] - 1, obs[0][35:24], want[cyc - LAT_A[0] - 2]);
                end
            end
        end
    endtask

    task automatic test_midreset();
        int target;
        logic [35:0] exp;
        target = 5 * h_total(1) + 30 + int'($urandom_range(0, 200));
        do_reset();
        while (cyc < target) begin
            @(negedge clk); cyc++;
            for (int k = 0; k < NDUT; k++) begin
                exp = model(k, cyc);
                nvec++;
                if (obs[k] !== exp) begin
                    nerr++;
                    $display("FAIL pre_reset dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp);
                end
            end
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            nvec++;
            if (obs[k] !== RESET_OBS) begin
                nerr++;
                $display("FAIL midframe_reset dut%0d: got %h expected %h", k, obs[k], RESET_OBS);
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = -1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk); cyc++;
            for (int k = 0; k < NDUT; k++) begin
                exp = model(k, cyc);
                nvec++;
                if (obs[k] !== exp) begin
                    nerr++;
                    $display("FAIL restart dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], exp);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        nvec = 0;
        nerr = 0;
        cyc = -1;
        for (int i = 0; i < 256; i++) begin
            tbl[i] = 8'($urandom);
            if ($urandom_range(0, 7) == 0) tbl[i] = 8'hEF;
        end
        tbl[1] = 8'hFF;
        tbl[2] = 8'h92;
        tbl[3] = 8'hEF;
        tbl[4] = 8'hEE;
        test_reset();
        test_first_pixel();
        test_scan();
        test_key_colors();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
